// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: size codes, FSM
// states, grant-owner encoding and the misalignment rule.
package dm_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Little-endian lane logic: merges store data into an old word and extracts
// zero/sign-extended sub-word loads from a word.
module dm_lane_unit
  import dm_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_B:    o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_H:    o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      SZ_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

  always_comb begin
    case (i_size)
      SZ_B:    o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_H:    o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      SZ_W:    o_rdata = i_word;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: round-robin CPU/external arbitration,
// two-cycle read-modify-write for sub-word stores, sub-word load extraction.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic [31:0]       ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       mem_rdata,
  output logic              dbg_state
);

  state_t      r_state;
  owner_t      r_last;
  logic [31:0] r_merge_q;

  logic              w_mis;
  logic              w_cpu_win;
  logic              w_ext_win;
  logic              w_cpu_sub_st;
  logic [ADDR_W-1:0] w_cpu_waddr;
  logic [ADDR_W-1:0] w_ext_waddr;
  logic [31:0]       w_merged;
  logic [31:0]       w_extract;
  logic              w_unused;

  // Handshake: cpu_ready high means the CPU access retires this cycle;
  // ext_gnt high means the external access is performed this cycle.
  assign w_mis        = is_misaligned(cpu_size, cpu_addr[1:0]);
  assign w_cpu_win    = (r_state == ST_IDLE) && cpu_req && (!ext_req || (r_last == OWN_EXT));
  assign w_ext_win    = (r_state == ST_IDLE) && ext_req && !w_cpu_win;
  assign w_cpu_sub_st = w_cpu_win && !w_mis && cpu_we && (cpu_size != SZ_W);
  assign w_cpu_waddr  = {cpu_addr[ADDR_W-1:2], 2'b00};
  assign w_ext_waddr  = {ext_addr[ADDR_W-1:2], 2'b00};
  assign w_unused     = ^ext_addr[1:0];
  assign ext_rdata    = mem_rdata;
  assign dbg_state    = r_state;

  dm_lane_unit u_lane (
    .i_word    (mem_rdata),
    .i_wdata   (cpu_wdata),
    .i_addr_lo (cpu_addr[1:0]),
    .i_size    (cpu_size),
    .i_sext    (cpu_sext),
    .o_merged  (w_merged),
    .o_rdata   (w_extract)
  );

  always_comb begin
    cpu_ready = !cpu_req;
    cpu_err   = 1'b0;
    cpu_rdata = 32'h0;
    ext_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = w_cpu_waddr;
    mem_wdata = cpu_wdata;
    mem_pc    = cpu_pc;
    if (reset) begin
      cpu_ready = 1'b0;
    end else if (r_state == ST_RMW_WR) begin
      mem_we    = 1'b1;
      mem_wdata = r_merge_q;
      cpu_ready = 1'b1;
    end else if (w_cpu_win) begin
      if (w_mis) begin
        cpu_err   = 1'b1;
        cpu_ready = 1'b1;
      end else if (cpu_we) begin
        mem_we    = !w_cpu_sub_st;
        cpu_ready = !w_cpu_sub_st;
      end else begin
        cpu_ready = 1'b1;
        cpu_rdata = w_extract;
      end
    end else if (w_ext_win) begin
      ext_gnt   = 1'b1;
      mem_addr  = w_ext_waddr;
      mem_we    = ext_we;
      mem_wdata = ext_wdata;
      mem_pc    = 32'h0;
    end
  end

  // A sub-word store only counts as complete once its merged word is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= OWN_EXT;
      r_merge_q <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_sub_st) begin
            r_merge_q <= w_merged;
            r_state   <= ST_RMW_WR;
          end else if (w_cpu_win) begin
            r_last <= OWN_CPU;
          end else if (w_ext_win) begin
            r_last <= OWN_EXT;
          end
        end
        ST_RMW_WR: begin
          r_state <= ST_IDLE;
          r_last  <= OWN_CPU;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a word memory model and an expected-data queue.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;
  logic        dbg_state;

  logic [31:0] mem [0:4095];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  dm_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_sext  (cpu_sext),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_pc    (cpu_pc),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_gnt   (ext_gnt),
    .ext_rdata (ext_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_pc    (mem_pc),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %h expected <none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc);
    cpu_req = req; cpu_we = we; cpu_size = size; cpu_sext = sext;
    cpu_addr = addr; cpu_wdata = wdata; cpu_pc = pc;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wdata;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] expv);
    cpu_drive(1'b1, 1'b0, size, sext, addr, 32'h0, 32'h0);
    exp_q.push_back(expv);
    mid();
    chk({tag, "_ready"}, 32'(cpu_ready), 32'h1);
    chk_q({tag, "_rdata"}, cpu_rdata);
    chk({tag, "_no_we"}, 32'(mem_we), 32'h0);
    next_cycle();
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    cpu_drive(1'b1, we, size, 1'b1, addr, 32'hFFFF_FFFF, 32'h300);
    mid();
    chk({tag, "_err"}, 32'(cpu_err), 32'h1);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'h1);
    chk({tag, "_no_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_rdata"}, cpu_rdata, 32'h0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    mid();
    chk({tag, "_pulse_end"}, 32'(cpu_err), 32'h0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset = 1'b1;
    cpu_drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h4, 32'h0);

    // reset with both sides requesting
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_ext_gnt", 32'(ext_gnt), 32'h0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("rst_cpu_err", 32'(cpu_err), 32'h0);
      next_cycle();
    end
    chk("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b0;

    // first tie to CPU, then alternate
    mid();
    chk("tie1_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("tie1_ext_gnt", 32'(ext_gnt), 32'h0);
    next_cycle();
    mid();
    chk("tie2_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("tie2_ext_gnt", 32'(ext_gnt), 32'h1);
    next_cycle();
    mid();
    chk("tie3_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("tie3_ext_gnt", 32'(ext_gnt), 32'h0);
    next_cycle();

    // word store then byte store (read-modify-write)
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cpu_drive(1'b1, 1'b1, SZ_W, 1'b0, 32'h10, 32'h1234_5678, 32'h100);
    exp_q.push_back(32'h1234_5678);
    mid();
    chk("wst_we", 32'(mem_we), 32'h1);
    chk_q("wst_wdata", mem_wdata);
    chk("wst_pc", mem_pc, 32'h100);
    chk("wst_ready", 32'(cpu_ready), 32'h1);
    next_cycle();

    cpu_drive(1'b1, 1'b1, SZ_B, 1'b0, 32'h11, 32'h0000_00AB, 32'h104);
    exp_q.push_back(32'h1234_AB78);
    mid();
    chk("bst_stall_ready", 32'(cpu_ready), 32'h0);
    chk("bst_stall_we", 32'(mem_we), 32'h0);
    chk("bst_stall_state", 32'(dbg_state), 32'h0);
    next_cycle();
    mid();
    chk("bst_wr_state", 32'(dbg_state), 32'h1);
    chk("bst_wr_we", 32'(mem_we), 32'h1);
    chk_q("bst_wr_wdata", mem_wdata);
    chk("bst_wr_pc", mem_pc, 32'h104);
    chk("bst_wr_addr", mem_addr, 32'h10);
    chk("bst_wr_ready", 32'(cpu_ready), 32'h1);
    next_cycle();
    chk("bst_mem", mem[4], 32'h1234_AB78);

    // sub-word loads
    do_load("ld_sb11", SZ_B, 1'b1, 32'h11, 32'hFFFF_FFAB);
    do_load("ld_ub11", SZ_B, 1'b0, 32'h11, 32'h0000_00AB);
    do_load("ld_uh12", SZ_H, 1'b0, 32'h12, 32'h0000_1234);
    do_load("ld_sh12", SZ_H, 1'b1, 32'h12, 32'h0000_1234);
    do_load("ld_sb10", SZ_B, 1'b1, 32'h10, 32'h0000_0078);
    do_load("ld_sh10", SZ_H, 1'b1, 32'h10, 32'hFFFF_AB78);
    do_load("ld_sb13", SZ_B, 1'b1, 32'h13, 32'h0000_0012);
    do_load("ld_w10",  SZ_W, 1'b1, 32'h10, 32'h1234_AB78);

    // contention: CPU won last, so external goes first
    cpu_drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h13, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic ext_turn;
      ext_turn = (i % 2 == 0);
      exp_q.push_back(32'h1234_AB78);
      mid();
      chk("cont_ext_gnt", 32'(ext_gnt), 32'(ext_turn));
      chk("cont_cpu_ready", 32'(cpu_ready), 32'(!ext_turn));
      chk_q("cont_data", ext_turn ? ext_rdata : cpu_rdata);
      next_cycle();
    end

    // external write
    cpu_drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b1, 32'h22, 32'hCAFE_F00D);
    mid();
    chk("extw_gnt", 32'(ext_gnt), 32'h1);
    chk("extw_we", 32'(mem_we), 32'h1);
    chk("extw_pc", mem_pc, 32'h0);
    chk("extw_addr", mem_addr, 32'h20);
    next_cycle();

    // half store with external read waiting behind it
    cpu_drive(1'b1, 1'b1, SZ_H, 1'b0, 32'h20, 32'h5555_BEEF, 32'h200);
    ext_drive(1'b1, 1'b0, 32'h20, 32'h0);
    exp_q.push_back(32'hCAFE_BEEF);
    mid();
    chk("rmw1_ready", 32'(cpu_ready), 32'h0);
    chk("rmw1_ext_gnt", 32'(ext_gnt), 32'h0);
    chk("rmw1_we", 32'(mem_we), 32'h0);
    next_cycle();
    mid();
    chk("rmw2_ext_gnt", 32'(ext_gnt), 32'h0);
    chk("rmw2_we", 32'(mem_we), 32'h1);
    chk_q("rmw2_wdata", mem_wdata);
    chk("rmw2_pc", mem_pc, 32'h200);
    chk("rmw2_ready", 32'(cpu_ready), 32'h1);
    next_cycle();
    cpu_drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(32'hCAFE_BEEF);
    mid();
    chk("rmw3_ext_gnt", 32'(ext_gnt), 32'h1);
    chk_q("rmw3_ext_rdata", ext_rdata);
    next_cycle();
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);

    // misaligned / illegal accesses
    do_err("err_h13", 1'b1, SZ_H, 32'h13);
    do_err("err_w12", 1'b0, SZ_W, 32'h12);
    do_err("err_sz3", 1'b0, 2'b11, 32'h10);
    do_err("err_h21", 1'b0, SZ_H, 32'h21);

    // reset during the write cycle of a read-modify-write
    cpu_drive(1'b1, 1'b1, SZ_B, 1'b0, 32'h21, 32'h0000_0055, 32'h400);
    mid();
    chk("rrst_stall_ready", 32'(cpu_ready), 32'h0);
    next_cycle();
    reset = 1'b1;
    mid();
    chk("rrst_no_we", 32'(mem_we), 32'h0);
    chk("rrst_ready", 32'(cpu_ready), 32'h0);
    next_cycle();
    reset = 1'b0;
    cpu_drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h20, 32'h0);
    exp_q.push_back(32'hCAFE_BEEF);
    mid();
    chk("rrst_state", 32'(dbg_state), 32'h0);
    chk("rrst_ext_gnt", 32'(ext_gnt), 32'h1);
    chk_q("rrst_ext_rdata", ext_rdata);
    next_cycle();
    chk("rrst_mem", mem[8], 32'hCAFE_BEEF);
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
